instr_decode_queue: RTL
=======================

Name: instr_decode_queue

Overview:
- Sits between instruction fetch and the issue stage.
- Takes the fetch stream of 16-bit instruction words and assembles one-word and two-word (immediate-carrying) instructions into types::instr_t records.
- Buffers the records in a parametrised-depth queue with valid/ready handshakes on both sides.
- Exports a busy flag that feeds csr_t.Busy.

Parameters:
- DEPTH, 4, number of instr_t entries in the queue (>=2).
- WORD_W, 16, fetch word width; must equal the instr_t immediate width (16).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  discard queue contents and any partial instruction.
- in_valid  in  1  fetch word present.
- in_ready  out  1  block accepts word this cycle.
- in_word  in  WORD_W  fetch word.
- out_valid  out  1  out_instr holds a valid record.
- out_ready  in  1  consumer takes the record this cycle.
- out_instr  out  32  types::instr_t record.
- busy  out  1  partial instruction held or queue non-empty.
- count  out  $clog2(DEPTH+1)  occupied entries.

Behaviour:
- Head word format: [15:12] opcode, [11] imm_valid, [10:8] funct, [7:4] dest_reg, [3:0] src_reg.
- imm_valid=1 means the next accepted word is the immediate. imm_valid=0 means imm=0.
- Record layout: out_instr = {head word, imm}; a short instruction is therefore {word, 16'h0}.
- Reset state: FSM in IDLE; queue empty; count=0, out_valid=0, busy=0, out_instr=0, in_ready=1.
- Handshakes:
  - Input fires on in_valid & in_ready; output fires on out_valid & out_ready.
  - in_ready = (count < DEPTH); it never combinationally depends on out_ready.
- FSM, state IDLE:
  - Fired word with bit11=0: push record {word,16'h0}; stay in IDLE.
  - Fired word with bit11=1: latch it in the head register; go to WAIT_IMM; nothing is pushed.
- FSM, state WAIT_IMM:
  - Fired word: push {head,word}; return to IDLE.
  - in_valid low: hold state indefinitely.
- Latency: a record pushed at edge N is visible as out_valid after edge N (registered output, queue head).
- Queue behaviour:
  - Push and pop in the same cycle: count is unchanged, and pointers wrap modulo DEPTH.
  - At full, in_ready=0, so no word is accepted in either FSM state.
  - At empty, out_valid=0 and out_instr holds its last value (not X).
- flush:
  - Synchronous; highest priority.
  - Next cycle: count=0, out_valid=0, FSM in IDLE, head register cleared.
  - Any input or output fire in the flush cycle is ignored: the word is dropped and nothing is popped.
- busy = (FSM==WAIT_IMM) | (count!=0).
- Reset asserted mid-instruction: the partial head and all entries are lost immediately (asynchronous).

Optional Feature:
- Macro: INSTR_DECODE_QUEUE_BYPASS_EN.
- Defined:
  - When the queue is empty and a record completes this cycle, it is presented combinationally on out_instr/out_valid in the same cycle.
  - If out_ready=1 in that cycle, the record is consumed without being written to the queue and count stays 0.
  - flush still suppresses bypass.
- Undefined: one-cycle minimum latency as described above.

Decomposition:
- types package:
  - Keep instr_t.
  - Add localparam INSTR_W=32.
  - Add localparams for head-word field positions (OPC_MSB=15, IMMV_BIT=11, etc.).
  - Add function decode_head(word, imm) returning instr_t, shared with the issue stage.
- Sub-module instr_decode_queue_fifo(DEPTH, WIDTH=INSTR_W): generic synchronous FIFO with push/pop/clear, count, full/empty.
- The top level holds only the FSM, the head register and the bypass mux.

Test Plan:
- Short instruction: reset, feed 0x1234 with out_ready=1 -> next cycle out_valid=1, out_instr=0x1234_0000, busy returns to 0 one cycle after the pop.
- Long instruction with gap: feed 0x5A67, idle 3 cycles, then 0xBEEF -> busy=1 and out_valid=0 during the gap; then out_instr=0x5A67_BEEF.
- Fill and back-pressure: DEPTH=4, out_ready=0, feed 5 short words 0x1000..0x4000, 0x5000 -> in_ready=0 after the 4th word; count=4; 0x5000 is accepted only after one pop; order is preserved.
- Concurrent push and pop: count=2, in/out fire together for 10 cycles -> count stays 2; outputs in FIFO order across pointer wrap.
- Flush mid-long: feed 0x5A67, then flush=1 with in_valid carrying 0xBEEF -> count=0, FSM in IDLE; a following 0x1234 emerges as 0x1234_0000, not {0x5A67,..}.
- Bypass (macro defined): queue empty, out_ready=1, feed 0x1234 -> out_valid=1 and out_instr=0x1234_0000 in the same cycle, count stays 0.

Source files
------------

// File: rtl/instr_decode_queue_pkg.sv
// Shared instruction record types and head-word field map for decode and issue.
// The optional same-cycle bypass is built only when INSTR_DECODE_QUEUE_BYPASS_EN is defined.
package instr_decode_queue_pkg;
  localparam int INSTR_W   = 32;
  localparam int IMM_W     = 16;
  localparam int OPC_MSB   = 15;
  localparam int OPC_LSB   = 12;
  localparam int IMMV_BIT  = 11;
  localparam int FUNCT_MSB = 10;
  localparam int FUNCT_LSB = 8;
  localparam int DEST_MSB  = 7;
  localparam int DEST_LSB  = 4;
  localparam int SRC_MSB   = 3;
  localparam int SRC_LSB   = 0;

  typedef struct packed {
    logic [3:0]       opcode;
    logic             imm_valid;
    logic [2:0]       funct;
    logic [3:0]       dest_reg;
    logic [3:0]       src_reg;
    logic [IMM_W-1:0] imm;
  } instr_t;

  typedef enum logic {IDLE = 1'b0, WAIT_IMM = 1'b1} dq_state_e;

  function automatic instr_t decode_head(input logic [IMM_W-1:0] word,
                                         input logic [IMM_W-1:0] imm);
    instr_t r;
    r.opcode    = word[OPC_MSB:OPC_LSB];
    r.imm_valid = word[IMMV_BIT];
    r.funct     = word[FUNCT_MSB:FUNCT_LSB];
    r.dest_reg  = word[DEST_MSB:DEST_LSB];
    r.src_reg   = word[SRC_MSB:SRC_LSB];
    r.imm       = imm;
    return r;
  endfunction
endpackage

// File: rtl/instr_decode_queue_fifo.sv
// Generic synchronous FIFO with clear; dout holds the last popped entry while empty.
module instr_decode_queue_fifo
  import instr_decode_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = INSTR_W
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clear,
  input  logic                       push,
  input  logic [WIDTH-1:0]           din,
  input  logic                       pop,
  output logic [WIDTH-1:0]           dout,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [DEPTH-1:0][WIDTH-1:0] mem;
  logic [PTR_W-1:0]            wr_ptr, rd_ptr;
  logic [CNT_W-1:0]            cnt;
  logic [WIDTH-1:0]            last_q;
  logic                        push_ok, pop_ok;

  // Explicit wrap so non-power-of-two depths work.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH-1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full    = (cnt == CNT_W'(DEPTH));
  assign empty   = (cnt == '0);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign count   = cnt;
  assign dout    = empty ? last_q : mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      last_q <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (pop_ok) begin
        last_q <= mem[rd_ptr];
        rd_ptr <= ptr_inc(rd_ptr);
      end
      case ({push_ok, pop_ok})
        2'b10:   cnt <= cnt + CNT_W'(1);
        2'b01:   cnt <= cnt - CNT_W'(1);
        default: cnt <= cnt;
      endcase
    end
  end
endmodule

// File: rtl/instr_decode_queue.sv
// Assembles 1/2-word fetch instructions into instr_t records and queues them for issue.
// Optional same-cycle bypass when the queue is empty: INSTR_DECODE_QUEUE_BYPASS_EN.
module instr_decode_queue
  import instr_decode_queue_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int WORD_W = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WORD_W-1:0]          in_word,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [INSTR_W-1:0]         out_instr,
  output logic                       busy,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  dq_state_e          state_q, state_d;
  logic [WORD_W-1:0]  head_q;
  logic               in_fire, head_load, complete, push, pop;
  logic               fifo_full, fifo_empty;
  logic [INSTR_W-1:0] fifo_dout;
  instr_t             rec;

  assign in_ready = ~fifo_full;
  assign in_fire  = in_valid & in_ready & ~flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     state_q <= IDLE;
    else if (flush) state_q <= IDLE;
    else            state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (in_fire) begin
      case (state_q)
        IDLE:     if (in_word[IMMV_BIT]) state_d = WAIT_IMM;
        WAIT_IMM: state_d = IDLE;
        default:  state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    head_load = 1'b0;
    complete  = 1'b0;
    rec       = decode_head(in_word, '0);
    case (state_q)
      IDLE: begin
        head_load = in_fire & in_word[IMMV_BIT];
        complete  = in_fire & ~in_word[IMMV_BIT];
      end
      WAIT_IMM: begin
        complete = in_fire;
        rec      = decode_head(head_q, in_word);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         head_q <= '0;
    else if (flush)     head_q <= '0;
    else if (head_load) head_q <= in_word;
  end

  assign pop = ~fifo_empty & out_ready & ~flush;

`ifdef INSTR_DECODE_QUEUE_BYPASS_EN
  logic byp;
  // complete already excludes flush, so bypass never fires in a flush cycle.
  assign byp       = fifo_empty & complete;
  assign push      = complete & ~(byp & out_ready);
  assign out_valid = ~fifo_empty | byp;
  assign out_instr = byp ? rec : fifo_dout;
`else
  assign push      = complete;
  assign out_valid = ~fifo_empty;
  assign out_instr = fifo_dout;
`endif

  assign busy = (state_q == WAIT_IMM) | (count != '0);

  instr_decode_queue_fifo #(.DEPTH(DEPTH), .WIDTH(INSTR_W)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (flush),
    .push  (push),
    .din   (rec),
    .pop   (pop),
    .dout  (fifo_dout),
    .count (count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );
endmodule
